// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types and constants for the RISC-V front end.
// Provides widths, the bubble encoding, the fetch FSM states and the IF/ID bundle.
package riscv_pipe_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instruction;
    logic            valid;
  } if_id_t;

  function automatic if_id_t bubble(input logic [ILEN-1:0] nop);
    if_id_t b;
    b.pc          = '0;
    b.instruction = nop;
    b.valid       = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register with load, hold and flush-to-bubble controls.
// Ports: clk, reset (async high), load, flush, d (next payload), q (held payload).
module if_id_register
  import riscv_pipe_pkg::*;
#(
  parameter logic [ILEN-1:0] BUBBLE_INST = riscv_pipe_pkg::NOP_INST
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= bubble(BUBBLE_INST);
    end else if (flush) begin
      q <= bubble(BUBBLE_INST);
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, the fetch FSM and the fetch counter, fills IF/ID.
// Ports: clk, reset, stall, branch_taken/target in; Inst_Address, IF/ID, status out.
module instruction_fetch_unit
  import riscv_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0,
  parameter logic [XLEN-1:0] END_ADDR = 64'd112,
  parameter logic [ILEN-1:0] NOP_INST = riscv_pipe_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic [ILEN-1:0] Instruction,
  output logic [XLEN-1:0] Inst_Address,
  output logic [XLEN-1:0] if_id_pc,
  output logic [ILEN-1:0] if_id_instruction,
  output logic            if_id_valid,
  output logic            halted,
  output logic            misalign_err,
  output logic [31:0]     fetch_count
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] pc, pc_n;
  logic [31:0]     cnt, cnt_n;
  logic            mis, mis_n;
  logic            load, flush;
  if_id_t          d, q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
      cnt   <= '0;
      mis   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      cnt   <= cnt_n;
      mis   <= mis_n;
    end
  end

  // Once a misaligned redirect has halted fetch, no branch may restart it.
  logic br_ok;
  assign br_ok = branch_taken && !(state == HALT && mis);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    mis_n   = mis;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state)
      BOOT: begin
        state_n = RUN;
      end
      RUN, HALT: begin
        if (br_ok) begin
          flush = 1'b1;
          if (branch_target[1:0] == 2'b00) begin
            pc_n    = branch_target;
            state_n = RUN;
          end else begin
            mis_n   = 1'b1;
            state_n = HALT;
          end
        end else if (stall) begin
          // hold everything
        end else if (state == HALT) begin
          flush = 1'b1;
        end else if (pc >= END_ADDR) begin
          flush   = 1'b1;
          state_n = HALT;
        end else begin
          load  = 1'b1;
          pc_n  = pc + 64'd4;
          cnt_n = cnt + 32'd1;
        end
      end
      default: begin
        state_n = BOOT;
      end
    endcase
  end

  always_comb begin
    d.pc          = pc;
    d.instruction = Instruction;
    d.valid       = 1'b1;
  end

  if_id_register #(
    .BUBBLE_INST (NOP_INST)
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .flush (flush),
    .d     (d),
    .q     (q)
  );

  assign Inst_Address      = pc;
  assign if_id_pc          = q.pc;
  assign if_id_instruction = q.instruction;
  assign if_id_valid       = q.valid;
  assign halted            = (state == HALT);
  assign misalign_err      = mis;
  assign fetch_count       = cnt;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit.
// Memory word i holds 0xA0000000+i, except word 0 holds 0x00500993.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [31:0] Instruction;
  logic [63:0] Inst_Address;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:31];

  always #5 clk = ~clk;

  assign Instruction = mem[Inst_Address[6:2]];

  instruction_fetch_unit dut (
    .clk               (clk),
    .reset             (reset),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .Instruction       (Instruction),
    .Inst_Address      (Inst_Address),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction),
    .if_id_valid       (if_id_valid),
    .halted            (halted),
    .misalign_err      (misalign_err),
    .fetch_count       (fetch_count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag,
                         input logic [63:0] pc,
                         input logic [63:0] ipc,
                         input logic [31:0] ins,
                         input logic        v,
                         input logic        h,
                         input logic [31:0] n);
    chk({tag, ".addr"}, Inst_Address, pc);
    chk({tag, ".ipc"}, if_id_pc, ipc);
    chk({tag, ".ins"}, {32'h0, if_id_instruction}, {32'h0, ins});
    chk({tag, ".v"}, {63'h0, if_id_valid}, {63'h0, v});
    chk({tag, ".halt"}, {63'h0, halted}, {63'h0, h});
    chk({tag, ".cnt"}, {32'h0, fetch_count}, {32'h0, n});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
    mem[0] = 32'h0050_0993;

    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    #12;
    chk_all("rst", 64'h0, 64'h0, 32'h13, 1'b0, 1'b0, 32'd0);
    chk("rst.mis", {63'h0, misalign_err}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // BOOT cycle with stall asserted: must be ignored
    stall = 1'b1;
    tick();
    chk_all("boot", 64'h0, 64'h0, 32'h13, 1'b0, 1'b0, 32'd0);
    stall = 1'b0;

    tick();
    chk_all("f0", 64'h4, 64'h0, 32'h0050_0993, 1'b1, 1'b0, 32'd1);
    tick();
    chk_all("f1", 64'h8, 64'h4, 32'hA000_0001, 1'b1, 1'b0, 32'd2);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("stall", 64'h8, 64'h4, 32'hA000_0001, 1'b1, 1'b0, 32'd2);
    end
    stall = 1'b0;
    tick();
    chk_all("f2", 64'hC, 64'h8, 32'hA000_0002, 1'b1, 1'b0, 32'd3);
    tick();
    chk_all("f3", 64'h10, 64'hC, 32'hA000_0003, 1'b1, 1'b0, 32'd4);

    tick();
    tick();
    tick();
    chk_all("f6", 64'h1C, 64'h18, 32'hA000_0006, 1'b1, 1'b0, 32'd7);

    branch_taken = 1'b1;
    branch_target = 64'h68;
    tick();
    chk_all("br", 64'h68, 64'h0, 32'h13, 1'b0, 1'b0, 32'd7);
    branch_taken = 1'b0;
    tick();
    chk_all("brt", 64'h6C, 64'h68, 32'hA000_001A, 1'b1, 1'b0, 32'd8);

    branch_taken = 1'b1;
    stall = 1'b1;
    branch_target = 64'h10;
    tick();
    chk_all("brst", 64'h10, 64'h0, 32'h13, 1'b0, 1'b0, 32'd8);
    branch_taken = 1'b0;
    stall = 1'b0;
    tick();
    chk_all("brst2", 64'h14, 64'h10, 32'hA000_0004, 1'b1, 1'b0, 32'd9);

    for (int i = 0; i < 23; i++) tick();
    chk_all("last", 64'h70, 64'h6C, 32'hA000_001B, 1'b1, 1'b0, 32'd32);
    tick();
    chk_all("end", 64'h70, 64'h0, 32'h13, 1'b0, 1'b1, 32'd32);
    tick();
    chk_all("hold", 64'h70, 64'h0, 32'h13, 1'b0, 1'b1, 32'd32);

    branch_taken = 1'b1;
    branch_target = 64'h40;
    tick();
    chk_all("resume", 64'h40, 64'h0, 32'h13, 1'b0, 1'b0, 32'd32);
    branch_taken = 1'b0;
    tick();
    chk_all("res2", 64'h44, 64'h40, 32'hA000_0010, 1'b1, 1'b0, 32'd33);

    branch_taken = 1'b1;
    branch_target = 64'h42;
    tick();
    chk_all("mis", 64'h44, 64'h0, 32'h13, 1'b0, 1'b1, 32'd33);
    chk("mis.err", {63'h0, misalign_err}, 64'h1);
    branch_target = 64'h20;
    tick();
    chk_all("misign", 64'h44, 64'h0, 32'h13, 1'b0, 1'b1, 32'd33);
    chk("mis.stk", {63'h0, misalign_err}, 64'h1);
    branch_taken = 1'b0;

    #1;
    reset = 1'b1;
    #1;
    chk_all("arst", 64'h0, 64'h0, 32'h13, 1'b0, 1'b0, 32'd0);
    chk("arst.mis", {63'h0, misalign_err}, 64'h0);
    #1;
    reset = 1'b0;
    tick();
    chk_all("boot2", 64'h0, 64'h0, 32'h13, 1'b0, 1'b0, 32'd0);
    tick();
    chk_all("f0b", 64'h4, 64'h0, 32'h0050_0993, 1'b1, 1'b0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
